// File: rtl/hms_timekeeper.sv
// hms_timekeeper: single-clock HMS timekeeping core -- tick divider, cascaded
// sec/min/hour counters, CLOCK/SETUP field editing, blink mask and alarm.
module hms_timekeeper #(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned TICK_HZ   = 1,
    parameter int unsigned HOUR_MAX  = 23,
    parameter int unsigned ALARM_SEC = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_mode_pls,
    input  logic       i_pos_pls,
    input  logic       i_inc_pls,
    input  logic       i_alarm_sel,
    input  logic       i_alarm_on,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hou,
    output logic [5:0] o_alm_min,
    output logic [4:0] o_alm_hou,
    output logic       o_mode,
    output logic [1:0] o_position,
    output logic [2:0] o_blink,
    output logic       o_tick,
    output logic       o_alarm
);
    localparam int unsigned DIV       = CLK_HZ / TICK_HZ;
    localparam int unsigned CW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned AW        = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;
    localparam int unsigned HOLD_LAST = (ALARM_SEC > 0) ? ALARM_SEC - 1 : 0;

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
    localparam logic [4:0]    HOU_LAST = 5'(HOUR_MAX);
    localparam logic [5:0]    MS_LAST  = 6'd59;

    typedef enum logic {ST_CLOCK = 1'b0, ST_SETUP = 1'b1} state_t;
    typedef enum logic [1:0] {POS_SEC = 2'd0, POS_MIN = 2'd1, POS_HOU = 2'd2} pos_t;

    state_t        state_q, state_d;
    pos_t          pos_q, pos_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic [5:0]    sec_q, sec_d, min_q, min_d, alm_min_q, alm_min_d;
    logic [4:0]    hou_q, hou_d, alm_hou_q, alm_hou_d;
    logic [AW-1:0] hold_q, hold_d;
    logic          alarm_q, alarm_d, tick_q, tick_d;
    logic [2:0]    blink_q, blink_d;

    logic tick, any_pls, hold_done, alarm_set, alarm_clr;

    function automatic logic [5:0] inc_ms(input logic [5:0] v);
        return (v == MS_LAST) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [4:0] inc_hou(input logic [4:0] v);
        return (v == HOU_LAST) ? 5'd0 : v + 5'd1;
    endfunction

    // Next-state: mode toggle wins; CLOCK counts on tick; SETUP edits fields.
    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        phase_d   = phase_q ^ ((cnt_q == CNT_HALF) || (cnt_q == CNT_LAST));
        sec_d     = sec_q;
        min_d     = min_q;
        hou_d     = hou_q;
        alm_min_d = alm_min_q;
        alm_hou_d = alm_hou_q;
        hold_d    = hold_q;
        alarm_d   = alarm_q;
        tick      = 1'b0;
        any_pls   = i_mode_pls | i_pos_pls | i_inc_pls;

        if (i_mode_pls) begin
            // A mode change restarts the divider, so a coincident wrap yields no tick.
            cnt_d   = '0;
            phase_d = 1'b0;
            if (state_q == ST_CLOCK) begin
                state_d = ST_SETUP;
                pos_d   = POS_SEC;
            end else begin
                state_d = ST_CLOCK;
            end
        end else if (state_q == ST_CLOCK) begin
            tick = (cnt_q == CNT_LAST);
            if (tick) begin
                sec_d = inc_ms(sec_q);
                if (sec_q == MS_LAST) begin
                    min_d = inc_ms(min_q);
                    if (min_q == MS_LAST) begin
                        hou_d = inc_hou(hou_q);
                    end
                end
            end
        end else begin
            if (i_inc_pls) begin
                case (pos_q)
                    POS_SEC: begin
                        if (!i_alarm_sel) sec_d = inc_ms(sec_q);
                    end
                    POS_MIN: begin
                        if (i_alarm_sel) alm_min_d = inc_ms(alm_min_q);
                        else             min_d     = inc_ms(min_q);
                    end
                    default: begin
                        if (i_alarm_sel) alm_hou_d = inc_hou(alm_hou_q);
                        else             hou_d     = inc_hou(hou_q);
                    end
                endcase
            end
            if (i_pos_pls) begin
                case (pos_q)
                    POS_SEC: pos_d = POS_MIN;
                    POS_MIN: pos_d = POS_HOU;
                    default: pos_d = POS_SEC;
                endcase
            end
        end

        // Alarm: clear sources beat a coincident set.
        hold_done = alarm_q && tick && (ALARM_SEC != 0) && (hold_q == AW'(HOLD_LAST));
        alarm_clr = any_pls || !i_alarm_on || hold_done;
        alarm_set = tick && (sec_q == MS_LAST) && (min_d == alm_min_q) && (hou_d == alm_hou_q);
        if (alarm_clr) begin
            alarm_d = 1'b0;
            hold_d  = '0;
        end else if (alarm_set) begin
            alarm_d = 1'b1;
            hold_d  = '0;
        end else if (alarm_q && tick && (ALARM_SEC != 0)) begin
            hold_d = hold_q + AW'(1);
        end

        tick_d  = tick;
        blink_d = 3'b000;
        if ((state_d == ST_SETUP) && phase_d) begin
            case (pos_d)
                POS_SEC: blink_d = 3'b001;
                POS_MIN: blink_d = 3'b010;
                default: blink_d = 3'b100;
            endcase
        end
    end

    // State and output registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_CLOCK;
            pos_q     <= POS_SEC;
            cnt_q     <= '0;
            phase_q   <= 1'b0;
            sec_q     <= '0;
            min_q     <= '0;
            hou_q     <= '0;
            alm_min_q <= '0;
            alm_hou_q <= '0;
            hold_q    <= '0;
            alarm_q   <= 1'b0;
            tick_q    <= 1'b0;
            blink_q   <= '0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            hou_q     <= hou_d;
            alm_min_q <= alm_min_d;
            alm_hou_q <= alm_hou_d;
            hold_q    <= hold_d;
            alarm_q   <= alarm_d;
            tick_q    <= tick_d;
            blink_q   <= blink_d;
        end
    end

    assign o_sec      = sec_q;
    assign o_min      = min_q;
    assign o_hou      = hou_q;
    assign o_alm_min  = alm_min_q;
    assign o_alm_hou  = alm_hou_q;
    assign o_mode     = (state_q == ST_SETUP);
    assign o_position = pos_q;
    assign o_blink    = blink_q;
    assign o_tick     = tick_q;
    assign o_alarm    = alarm_q;

endmodule

// File: tb/tb_hms_timekeeper.sv
// Bench for hms_timekeeper: vector table, directed sequences and random
// stimulus, all compared against a seconds-of-day reference model.
module tb_hms_timekeeper;
    localparam int CLK_HZ    = 8;
    localparam int TICK_HZ   = 1;
    localparam int HOUR_MAX  = 23;
    localparam int ALARM_SEC = 3;
    localparam int DIV       = CLK_HZ / TICK_HZ;
    localparam int DAY       = (HOUR_MAX + 1) * 3600;

    logic       clk, rst_n;
    logic       mode_pls, pos_pls, inc_pls, alarm_sel, alarm_on;
    logic [5:0] o_sec, o_min, o_alm_min;
    logic [4:0] o_hou, o_alm_hou;
    logic       o_mode, o_tick, o_alarm;
    logic [1:0] o_position;
    logic [2:0] o_blink;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: time as seconds of day, alarm as minute of day.
    int m_t, m_am, m_ah, m_pos, m_k, m_hold;
    bit m_mode, m_tick, m_alarm;

    hms_timekeeper #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .HOUR_MAX(HOUR_MAX), .ALARM_SEC(ALARM_SEC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_mode_pls(mode_pls), .i_pos_pls(pos_pls), .i_inc_pls(inc_pls),
        .i_alarm_sel(alarm_sel), .i_alarm_on(alarm_on),
        .o_sec(o_sec), .o_min(o_min), .o_hou(o_hou),
        .o_alm_min(o_alm_min), .o_alm_hou(o_alm_hou),
        .o_mode(o_mode), .o_position(o_position), .o_blink(o_blink),
        .o_tick(o_tick), .o_alarm(o_alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       mp, pp, ip, asel;
        logic       exp_mode;
        logic [1:0] exp_pos;
        logic [5:0] exp_sec, exp_min;
        logic [4:0] exp_hou;
        logic [5:0] exp_amin;
    } vec_t;

    vec_t vecs[13];

    function automatic void model_step(input logic rst, input logic mp, input logic pp,
                                       input logic ip, input logic asel, input logic aon);
        bit tick, set, clr;
        int s, mm, hh;
        tick = 1'b0;
        if (!rst) begin
            m_t = 0; m_am = 0; m_ah = 0; m_pos = 0; m_k = 0; m_hold = 0;
            m_mode = 1'b0; m_tick = 1'b0; m_alarm = 1'b0;
            return;
        end
        if (mp) begin
            m_mode = !m_mode;
            m_k    = 0;
            if (m_mode) m_pos = 0;
        end else begin
            m_k++;
            if (!m_mode) begin
                tick = (m_k % DIV == 0);
            end else begin
                if (ip) begin
                    s  = m_t % 60;
                    mm = (m_t / 60) % 60;
                    hh = m_t / 3600;
                    if (m_pos == 0 && !asel) m_t += (s + 1) % 60 - s;
                    else if (m_pos == 1 && asel) m_am = (m_am + 1) % 60;
                    else if (m_pos == 1) m_t += ((mm + 1) % 60 - mm) * 60;
                    else if (m_pos == 2 && asel) m_ah = (m_ah + 1) % (HOUR_MAX + 1);
                    else if (m_pos == 2) m_t += ((hh + 1) % (HOUR_MAX + 1) - hh) * 3600;
                end
                if (pp) m_pos = (m_pos + 1) % 3;
            end
        end
        if (tick) m_t = (m_t + 1) % DAY;
        set = tick && (m_t % 60 == 0) && (m_t / 60 == m_ah * 60 + m_am) && aon;
        clr = mp || pp || ip || !aon || (m_alarm && tick && m_hold + 1 == ALARM_SEC);
        if (clr) m_alarm = 1'b0;
        else if (set) begin
            m_alarm = 1'b1;
            m_hold  = 0;
        end else if (m_alarm && tick) m_hold++;
        m_tick = tick;
    endfunction

    function automatic logic [35:0] model_vec();
        logic [2:0] bl;
        bl = (m_mode && ((m_k / (DIV / 2)) % 2 == 1)) ? 3'(1 << m_pos) : 3'b000;
        return {6'(m_t % 60), 6'((m_t / 60) % 60), 5'(m_t / 3600), 6'(m_am), 5'(m_ah),
                m_mode, 2'(m_pos), bl, m_tick, m_alarm};
    endfunction

    function automatic logic [35:0] dut_vec();
        return {o_sec, o_min, o_hou, o_alm_min, o_alm_hou, o_mode, o_position,
                o_blink, o_tick, o_alarm};
    endfunction

    task automatic check(input string name, input logic [35:0] got, input logic [35:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One clock: drive pulses, advance the model, sample on the falling edge.
    task automatic cycle(input logic mp, input logic pp, input logic ip);
        mode_pls = mp;
        pos_pls  = pp;
        inc_pls  = ip;
        model_step(rst_n, mp, pp, ip, alarm_sel, alarm_on);
        @(posedge clk);
        @(negedge clk);
        check("model", dut_vec(), model_vec());
        mode_pls = 1'b0;
        pos_pls  = 1'b0;
        inc_pls  = 1'b0;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        int cs, cm, ch;
        cs = m_t % 60;
        cm = (m_t / 60) % 60;
        ch = m_t / 3600;
        alarm_sel = 1'b0;
        cycle(1'b1, 1'b0, 1'b0);
        repeat ((s - cs + 60) % 60) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        repeat ((m - cm + 60) % 60) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        repeat ((h - ch + HOUR_MAX + 1) % (HOUR_MAX + 1)) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
    endtask

    task automatic set_alarm(input int h, input int m);
        int cm, ch;
        cm = m_am;
        ch = m_ah;
        cycle(1'b1, 1'b0, 1'b0);
        alarm_sel = 1'b1;
        cycle(1'b0, 1'b1, 1'b0);
        repeat ((m - cm + 60) % 60) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        repeat ((h - ch + HOUR_MAX + 1) % (HOUR_MAX + 1)) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        alarm_sel = 1'b0;
        cycle(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        int ticks, first, last, gaps, changes, bad;
        logic [2:0] prev;

        //            mp    pp    ip    asel  mode  pos   sec   min   hou   amin
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 6'd0, 6'd0, 5'd0, 6'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 6'd1, 6'd0, 5'd0, 6'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 6'd1, 6'd1, 5'd0, 6'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 6'd1, 6'd1, 5'd0, 6'd0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 6'd1, 6'd1, 5'd1, 6'd0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 6'd1, 6'd1, 5'd1, 6'd0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 6'd1, 6'd1, 5'd1, 6'd0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 6'd1, 6'd1, 5'd1, 6'd0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 6'd1, 6'd1, 5'd1, 6'd1};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 6'd1, 6'd1, 5'd1, 6'd1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 6'd1, 6'd1, 5'd1, 6'd1};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 6'd1, 6'd1, 5'd1, 6'd1};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 6'd1, 6'd1, 5'd1, 6'd1};

        rst_n = 1'b0; mode_pls = 1'b0; pos_pls = 1'b0; inc_pls = 1'b0;
        alarm_sel = 1'b0; alarm_on = 1'b0;
        @(negedge clk);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        check("reset_state", dut_vec(), 36'd0);
        rst_n = 1'b1;

        // Edit table: simultaneous pulses, wraps, alarm-select routing.
        for (int i = 0; i < 13; i++) begin
            alarm_sel = vecs[i].asel;
            cycle(vecs[i].mp, vecs[i].pp, vecs[i].ip);
            check($sformatf("vec%0d", i),
                  36'({o_mode, o_position, o_sec, o_min, o_hou, o_alm_min}),
                  36'({vecs[i].exp_mode, vecs[i].exp_pos, vecs[i].exp_sec,
                       vecs[i].exp_min, vecs[i].exp_hou, vecs[i].exp_amin}));
        end
        alarm_sel = 1'b0;

        // Reset in the middle of SETUP, then free run from release.
        rst_n = 1'b0;
        cycle(1'b0, 1'b0, 1'b1);
        check("reset_mid_edit", dut_vec(), 36'd0);
        rst_n = 1'b1;
        ticks = 0; first = 0; last = 0; gaps = 0;
        for (int i = 1; i <= 480; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            if (o_tick === 1'b1) begin
                ticks++;
                if (first == 0) first = i;
                if (last != 0 && i - last != DIV) gaps++;
                last = i;
            end
        end
        check("free_tick_count", 36'(ticks), 36'd60);
        check("free_first_tick", 36'(first), 36'd8);
        check("free_tick_spacing", 36'(gaps), 36'd0);
        check("free_time", 36'({o_hou, o_min, o_sec}), 36'({5'd0, 6'd1, 6'd0}));

        // Rollover at HOUR_MAX.
        set_time(23, 59, 58);
        check("rollover_set", 36'({o_hou, o_min, o_sec}), 36'({5'd23, 6'd59, 6'd58}));
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            if (i == 8)
                check("rollover_59", 36'({o_hou, o_min, o_sec}), 36'({5'd23, 6'd59, 6'd59}));
            if (i == 16)
                check("rollover_wrap", 36'({o_hou, o_min, o_sec}), 36'({5'd0, 6'd0, 6'd0}));
        end

        // Minute wrap without carry, then blink cadence on MIN.
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        repeat (61) cycle(1'b0, 1'b0, 1'b1);
        check("edit_wrap", 36'({o_hou, o_min, o_sec, o_position}),
              36'({5'd0, 6'd1, 6'd0, 2'd1}));
        prev = o_blink; changes = 0; bad = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            if (o_blink !== 3'b010 && o_blink !== 3'b000) bad++;
            if (o_blink !== prev) changes++;
            prev = o_blink;
        end
        check("blink_values", 36'(bad), 36'd0);
        check("blink_toggles", 36'(changes), 36'd4);
        cycle(1'b1, 1'b0, 1'b0);

        // Alarm: rise with the minute, fall after ALARM_SEC further ticks.
        alarm_on = 1'b1;
        set_alarm(0, 1);
        check("alarm_regs", 36'({o_alm_hou, o_alm_min}), 36'({5'd0, 6'd1}));
        set_time(0, 0, 59);
        for (int i = 1; i <= 32; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            if (i == 7)  check("alarm_before", 36'({o_alarm, o_min, o_sec}), 36'({1'b0, 6'd0, 6'd59}));
            if (i == 8)  check("alarm_rise", 36'({o_alarm, o_min, o_sec}), 36'({1'b1, 6'd1, 6'd0}));
            if (i == 31) check("alarm_hold", 36'(o_alarm), 36'd1);
            if (i == 32) check("alarm_fall", 36'(o_alarm), 36'd0);
        end

        // Alarm cleared by a pulse, then by alarm_on going low.
        set_time(0, 0, 59);
        for (int i = 1; i <= 12; i++) begin
            cycle(1'b0, 1'b0, i == 12);
            if (i == 11) check("alarm_pre_pulse", 36'(o_alarm), 36'd1);
            if (i == 12) check("alarm_pulse_clr", 36'(o_alarm), 36'd0);
        end
        set_time(0, 0, 59);
        for (int i = 1; i <= 9; i++) begin
            alarm_on = (i != 9);
            cycle(1'b0, 1'b0, 1'b0);
            if (i == 8) check("alarm_rise2", 36'(o_alarm), 36'd1);
            if (i == 9) check("alarm_off_clr", 36'(o_alarm), 36'd0);
        end
        alarm_on = 1'b1;

        // Random traffic against the model.
        set_alarm(0, 2);
        set_time(0, 1, 55);
        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom_range(0, 999) != 0);
            alarm_sel = ($urandom_range(0, 3) == 0);
            alarm_on  = ($urandom_range(0, 15) != 0);
            cycle($urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 7) == 0);
        end
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
